// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the burst arbiter in front of the asymmetric FIFO:
// the flush sequencer states and the per-requester burst counter width.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int CntWidth = 16;

endpackage

// File: rtl/fifo_burst_arbiter_rr_pick.sv
// Round-robin priority search: first valid requester at or after ptr_i, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IdW = $clog2(NUM_REQ);

  // Scan from the farthest offset back to the pointer so the nearest hit wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid_i[(int'(ptr_i) + i) % NUM_REQ]) begin
        idx_o = IdW'((int'(ptr_i) + i) % NUM_REQ);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Round-robin arbiter that forwards whole N_IN-item bursts into an asymmetric
// FIFO through a one-deep output register, with a drain/flush/done sequence.
module fifo_burst_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  N_IN       = 2,
  parameter int  DATA_WIDTH = 32,
  parameter type dtype      = logic [DATA_WIDTH-1:0]
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  dtype [NUM_REQ-1:0][N_IN-1:0]         req_data_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic                                 fifo_full_i,
  output logic                                 fifo_push_o,
  output dtype [N_IN-1:0]                      fifo_data_o,
  output logic                                 fifo_flush_o,
  input  logic                                 flush_req_i,
  output logic                                 flush_done_o,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id_o,
  output logic [NUM_REQ-1:0][CntWidth-1:0]     burst_cnt_o
);

  localparam int IdW = $clog2(NUM_REQ);

  arb_state_e                        state_q, state_d;
  logic [IdW-1:0]                    rr_ptr_q;
  logic [IdW-1:0]                    winner;
  logic                              any_valid;
  logic                              accept;
  logic                              xfer;
  logic                              out_valid_q;
  dtype [N_IN-1:0]                   out_data_q;
  logic [IdW-1:0]                    out_id_q;
  logic [NUM_REQ-1:0][CntWidth-1:0]  cnt_q;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [IdW-1:0] ptr_after(input logic [IdW-1:0] idx);
    return (idx == IdW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (winner),
    .any_o   (any_valid)
  );

  assign xfer = out_valid_q & ~fifo_full_i;

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    req_ready_o  = '0;
    fifo_flush_o = 1'b0;
    flush_done_o = 1'b0;
    case (state_q)
      RUN: begin
        // The output slot is free if empty or emptying this cycle.
        accept = any_valid & (~out_valid_q | xfer);
        if (accept) req_ready_o[winner] = 1'b1;
        if (flush_req_i) state_d = DRAIN;
      end
      DRAIN: state_d = FLUSH;
      FLUSH: begin
        fifo_flush_o = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        flush_done_o = 1'b1;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Output register stage: accepted burst is presented to the FIFO next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= req_data_i[winner];
        out_id_q    <= winner;
        rr_ptr_q    <= ptr_after(winner);
      end else if (xfer || state_q == DRAIN) begin
        out_valid_q <= 1'b0;
      end
      if (state_q == FLUSH) rr_ptr_q <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == FLUSH) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q[out_id_q] <= sat_inc(cnt_q[out_id_q]);
    end
  end

  assign fifo_push_o = out_valid_q;
  assign fifo_data_o = out_data_q;
  assign grant_id_o  = out_id_q;
  assign burst_cnt_o = cnt_q;

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Bench for fifo_burst_arbiter: directed vector table, hand-written flush and
// reset sequences, randomized traffic against a reference model, saturation.
module tb_fifo_burst_arbiter;

  localparam int NR = 4;
  localparam int NI = 2;
  localparam int DW = 32;

  logic                         clk = 1'b0;
  logic                         rst_ni = 1'b0;
  logic [NR-1:0]                req_valid = '0;
  logic [NR-1:0][NI-1:0][DW-1:0] req_data = '0;
  logic [NR-1:0]                req_ready;
  logic                         fifo_full = 1'b0;
  logic                         fifo_push;
  logic [NI-1:0][DW-1:0]        fifo_data;
  logic                         fifo_flush;
  logic                         flush_req = 1'b0;
  logic                         flush_done;
  logic [1:0]                   grant_id;
  logic [NR-1:0][15:0]          burst_cnt;

  int total = 0;
  int bad   = 0;

  fifo_burst_arbiter #(
    .NUM_REQ    (NR),
    .N_IN       (NI),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .fifo_full_i  (fifo_full),
    .fifo_push_o  (fifo_push),
    .fifo_data_o  (fifo_data),
    .fifo_flush_o (fifo_flush),
    .flush_req_i  (flush_req),
    .flush_done_o (flush_done),
    .grant_id_o   (grant_id),
    .burst_cnt_o  (burst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic       full;
    logic [7:0] seed;
    logic [3:0] exp_ready;
    logic       exp_push;
    logic [1:0] exp_gid;
    logic [7:0] exp_seed;
  } vec_t;

  vec_t tbl[16];

  // Reference model state
  bit          m_held;
  logic [63:0] m_data;
  int          m_id;
  int          m_ptr;
  int          m_phase;
  int          m_cnt[NR];

  function automatic logic [63:0] mk(input int r, input int s);
    return {32'(32'hB000_0000 + s * 256 + r * 16 + 1), 32'(32'hA000_0000 + s * 256 + r * 16)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_seed(input int s);
    for (int r = 0; r < NR; r++) req_data[r] = mk(r, s);
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    m_held = 0; m_data = '0; m_id = 0; m_ptr = 0; m_phase = 0;
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
  endtask

  function automatic logic [63:0] model_cnt();
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < NR; r++) v[r*16 +: 16] = 16'(m_cnt[r]);
    return v;
  endfunction

  initial begin
    // round robin over 0,1,3 then idle
    tbl[0]  = '{4'b1011, 1'b0, 8'd1, 4'b0001, 1'b0, 2'd0, 8'd1};
    tbl[1]  = '{4'b1011, 1'b0, 8'd1, 4'b0010, 1'b1, 2'd0, 8'd1};
    tbl[2]  = '{4'b1011, 1'b0, 8'd1, 4'b1000, 1'b1, 2'd1, 8'd1};
    tbl[3]  = '{4'b1011, 1'b0, 8'd1, 4'b0001, 1'b1, 2'd3, 8'd1};
    tbl[4]  = '{4'b1011, 1'b0, 8'd1, 4'b0010, 1'b1, 2'd0, 8'd1};
    tbl[5]  = '{4'b1011, 1'b0, 8'd1, 4'b1000, 1'b1, 2'd1, 8'd1};
    tbl[6]  = '{4'b0000, 1'b0, 8'd1, 4'b0000, 1'b1, 2'd3, 8'd1};
    tbl[7]  = '{4'b0000, 1'b0, 8'd1, 4'b0000, 1'b0, 2'd0, 8'd1};
    // backpressure: burst from req 2 held across five full cycles while inputs change
    tbl[8]  = '{4'b0100, 1'b1, 8'd1, 4'b0100, 1'b0, 2'd0, 8'd1};
    tbl[9]  = '{4'b0100, 1'b1, 8'd2, 4'b0000, 1'b1, 2'd2, 8'd1};
    tbl[10] = '{4'b0100, 1'b1, 8'd3, 4'b0000, 1'b1, 2'd2, 8'd1};
    tbl[11] = '{4'b0100, 1'b1, 8'd4, 4'b0000, 1'b1, 2'd2, 8'd1};
    tbl[12] = '{4'b0100, 1'b1, 8'd5, 4'b0000, 1'b1, 2'd2, 8'd1};
    tbl[13] = '{4'b0100, 1'b1, 8'd6, 4'b0000, 1'b1, 2'd2, 8'd1};
    tbl[14] = '{4'b0000, 1'b0, 8'd7, 4'b0000, 1'b1, 2'd2, 8'd1};
    tbl[15] = '{4'b0000, 1'b0, 8'd7, 4'b0000, 1'b0, 2'd0, 8'd1};

    // reset state
    drive_seed(1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_push",  64'(fifo_push), 64'd0);
    chk("rst_flush", 64'(fifo_flush), 64'd0);
    chk("rst_done",  64'(flush_done), 64'd0);
    chk("rst_gid",   64'(grant_id), 64'd0);
    chk("rst_cnt",   64'(burst_cnt), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // directed vector table
    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].valid;
      fifo_full = tbl[i].full;
      drive_seed(int'(tbl[i].seed));
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_push", i), 64'(fifo_push), 64'(tbl[i].exp_push));
      if (tbl[i].exp_push) begin
        chk($sformatf("tbl%0d_gid", i), 64'(grant_id), 64'(tbl[i].exp_gid));
        chk($sformatf("tbl%0d_data", i), 64'(fifo_data),
            mk(int'(tbl[i].exp_gid), int'(tbl[i].exp_seed)));
      end
      @(posedge clk);
      #1;
    end
    chk("tbl_cnt", 64'(burst_cnt), 64'h0002_0001_0002_0002);

    // flush while full with a burst held
    req_valid = 4'b0010; fifo_full = 1'b1; drive_seed(9);
    @(negedge clk); chk("fl_acc_ready", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0000; flush_req = 1'b1;
    @(negedge clk); chk("fl_req_push", 64'(fifo_push), 64'd1);
    chk("fl_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush_req = 1'b0;
    @(negedge clk); chk("fl_drain_push", 64'(fifo_push), 64'd1);
    chk("fl_drain_flush", 64'(fifo_flush), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("fl_flush", 64'(fifo_flush), 64'd1);
    chk("fl_flush_push", 64'(fifo_push), 64'd0);
    chk("fl_flush_done", 64'(flush_done), 64'd0);
    @(posedge clk); #1;
    req_valid = 4'b1111; fifo_full = 1'b0;
    @(negedge clk); chk("fl_done", 64'(flush_done), 64'd1);
    chk("fl_done_flush", 64'(fifo_flush), 64'd0);
    chk("fl_done_ready", 64'(req_ready), 64'd0);
    chk("fl_cnt_clear", 64'(burst_cnt), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("fl_run_ready", 64'(req_ready), 64'b0001);
    chk("fl_run_done", 64'(flush_done), 64'd0);
    @(posedge clk); #1;

    // asynchronous reset while a burst is held
    req_valid = 4'b0000; fifo_full = 1'b1;
    @(negedge clk); chk("rm_push_before", 64'(fifo_push), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rm_push_async", 64'(fifo_push), 64'd0);
    @(posedge clk); #1;
    req_valid = 4'b1010; fifo_full = 1'b0; drive_seed(11);
    @(negedge clk); chk("rm_push_in_rst", 64'(fifo_push), 64'd0);
    chk("rm_gid_in_rst", 64'(grant_id), 64'd0);
    #1;
    rst_ni = 1'b1;
    #1;
    chk("rm_first_ready", 64'(req_ready), 64'b0010);
    chk("rm_push_after", 64'(fifo_push), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("rm_first_gid", 64'(grant_id), 64'd1);
    chk("rm_first_push", 64'(fifo_push), 64'd1);

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      logic [3:0]  v;
      logic        f;
      logic        fl;
      logic [3:0]  exp_rdy;
      logic [63:0] acc_data;
      int          w;
      bit          acc;
      bit          xf;
      v  = 4'($urandom);
      f  = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 29) == 0);
      req_valid = v; fifo_full = f; flush_req = fl;
      for (int r = 0; r < NR; r++) req_data[r] = {$urandom, $urandom};
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && v[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      acc     = (m_phase == 0) && (w >= 0) && (!m_held || !f);
      exp_rdy = acc ? 4'(1 << w) : 4'd0;
      acc_data = acc ? 64'(req_data[w]) : 64'd0;
      @(negedge clk);
      chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rnd_push",  64'(fifo_push), 64'(m_held));
      chk("rnd_flush", 64'(fifo_flush), 64'(m_phase == 2));
      chk("rnd_done",  64'(flush_done), 64'(m_phase == 3));
      if (m_held) begin
        chk("rnd_gid",  64'(grant_id), 64'(m_id));
        chk("rnd_data", 64'(fifo_data), m_data);
      end
      chk("rnd_cnt", 64'(burst_cnt), model_cnt());
      @(posedge clk);
      xf = m_held && !f;
      if (xf && m_cnt[m_id] < 65535) m_cnt[m_id]++;
      case (m_phase)
        0: begin
          if (acc) begin
            m_held = 1; m_data = acc_data; m_id = w; m_ptr = (w + 1) % NR;
          end else if (xf) begin
            m_held = 0;
          end
          if (fl) m_phase = 1;
        end
        1: begin m_held = 0; m_phase = 2; end
        2: begin
          for (int r = 0; r < NR; r++) m_cnt[r] = 0;
          m_ptr = 0; m_phase = 3;
        end
        default: m_phase = 0;
      endcase
      #1;
    end

    // counter saturation: more than 65535 bursts from requester 2
    do_reset();
    req_valid = 4'b0100; fifo_full = 1'b0; drive_seed(3);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_cnt2", 64'(burst_cnt[2]), 64'hFFFF);
    chk("sat_cnt0", 64'(burst_cnt[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_arbiter.md
FIFO_BURST_ARBITER -- requirements
Module: fifo_burst_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of burst requesters (2..8).
REQ-002 SHALL have parameter N_IN, default 2: items per burst, equal to the downstream asymmetric FIFO burst width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: item width.
REQ-004 SHALL have parameter type dtype, default logic [DATA_WIDTH-1:0]: item type.
REQ-005 SHALL have port clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid_i  in  NUM_REQ  per-requester burst valid.
REQ-008 SHALL have port req_data_i  in  NUM_REQ x N_IN x dtype  per-requester burst payload.
REQ-009 SHALL have port req_ready_o  out  NUM_REQ  one-hot-or-zero burst accept.
REQ-010 SHALL have port fifo_full_i  in  1  downstream cannot accept N_IN items.
REQ-011 SHALL have port fifo_push_o  out  1  burst push to FIFO.
REQ-012 SHALL have port fifo_data_o  out  N_IN x dtype  burst payload to FIFO.
REQ-013 SHALL have port fifo_flush_o  out  1  single-cycle FIFO flush.
REQ-014 SHALL have port flush_req_i  in  1  software flush request.
REQ-015 SHALL have port flush_done_o  out  1  single-cycle flush completion pulse.
REQ-016 SHALL have port grant_id_o  out  $clog2(NUM_REQ)  requester index of the burst currently on fifo_data_o.
REQ-017 SHALL have port burst_cnt_o  out  NUM_REQ x 16  per-requester count of bursts pushed.

Function
REQ-018 SHALL arbitrate round-robin: the winner is the lowest index >= rr_ptr_q with req_valid_i set, searching with wrap; rr_ptr_q resets to 0.
REQ-019 SHALL accept a burst (req_ready_o[winner]=1) only in state RUN and only when out_valid_q=0 or the held burst transfers this cycle (out_valid_q & ~fifo_full_i).
REQ-020 SHALL set rr_ptr_q to (winner+1) mod NUM_REQ on accept; with no accept it is unchanged.
REQ-021 SHALL register an accepted burst into out_data_q/out_id_q with out_valid_q=1, giving fifo_push_o exactly 1 cycle after accept.
REQ-022 SHALL drive fifo_push_o=out_valid_q, fifo_data_o=out_data_q and grant_id_o=out_id_q; the burst transfers when fifo_push_o & ~fifo_full_i.
REQ-023 SHALL hold out_data_q stable while fifo_full_i=1, sustaining 1 burst/cycle when not full (accept and transfer in the same cycle).
REQ-024 SHALL allow req_ready_o to depend combinationally on req_valid_i and fifo_full_i; requesters SHALL NOT make valid depend on ready.
REQ-025 SHALL increment burst_cnt_o[out_id_q] on each transfer, saturating at 16'hFFFF.
REQ-026 SHALL implement FSM RUN -> DRAIN -> FLUSH -> DONE -> RUN; flush_req_i is sampled only in RUN.
REQ-027 In DRAIN (exactly one cycle), SHALL assert no req_ready_o and still push the held burst if ~fifo_full_i; otherwise SHALL discard it. out_valid_q=0 on exit.
REQ-028 In FLUSH (one cycle), SHALL assert fifo_flush_o=1, clear all burst_cnt_o and set rr_ptr_q to 0.
REQ-029 In DONE (one cycle), SHALL assert flush_done_o=1 and no req_ready_o; RUN resumes on the next cycle.
REQ-030 When flush_req_i rises in the same cycle as an accept in RUN, SHALL complete that accept, then enter DRAIN.

Reset
REQ-031 On rst_ni low, SHALL force state=RUN, rr_ptr_q=0, out_valid_q=0, out_data_q=0, out_id_q=0, burst_cnt=0; outputs fifo_push_o=0, fifo_flush_o=0, flush_done_o=0, grant_id_o=0.
REQ-032 SHALL discard any in-flight burst on reset mid-operation, with no push after reset release until a new accept.

Structure
REQ-033 SHALL place the FSM state enum (RUN, DRAIN, FLUSH, DONE) and the CntWidth=16 constant in shared package fifo_arb_pkg.
REQ-034 SHALL contain one sub-module rr_pick: combinational priority search taking valid vector and pointer, returning winner index and any-valid.

Verification
REQ-035 Round-robin: NUM_REQ=4, req 0,1,3 held valid, fifo_full_i=0 -> pushes carry grant_id 0,1,3,0,1,3 on consecutive cycles.
REQ-036 Backpressure: fifo_full_i=1 for 5 cycles with burst {A,B} held -> fifo_data_o stays {A,B}, req_ready_o=0, one push counted after release.
REQ-037 Flush: flush_req_i pulse while full with burst held -> DRAIN discards it, fifo_flush_o high 1 cycle, flush_done_o the next, burst_cnt all 0.
REQ-038 Saturation: force 65537 bursts from req 2 -> burst_cnt_o[2]=16'hFFFF.
REQ-039 Reset mid-push: rst_ni low while out_valid_q=1 -> fifo_push_o=0 next cycle, rr_ptr_q=0; first grant after release goes to the lowest valid index.
